crc8_packet_engine: RTL and testbench

Computes a CRC-8 per packet over a stream of 32-bit packet words and packs the resulting CRC bytes, four per word, into 32-bit byte-enabled writes. It sits directly upstream of the CRC FIFO in the packet-processing path. Its `data_o`/`we_o` pair drives the FIFO's 32-bit data / 4-bit write-enable inputs, with the first CRC in byte lane 0.

---
 rtl/crc8_packet_engine.sv | 122 ++++++++++++
 tb/tb_crc8_packet_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/crc8_packet_engine.sv
// crc8_packet_engine: per-packet CRC-8 over 32-bit words, packed four CRC bytes per byte-enabled write
module crc8_packet_engine #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_data_i,
  input  logic [3:0]  s_be_i,
  input  logic        s_last_i,
  input  logic        flush_i,
  output logic [31:0] data_o,
  output logic [3:0]  we_o,
  output logic        busy_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PROC = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  be_q, be_d;
  logic        last_q, last_d;
  logic [7:0]  crc_q, crc_d;
  logic [1:0]  slot_cnt_q, slot_cnt_d;
  logic [31:0] slots_q, slots_d;
  logic [31:0] dout_q, dout_d;
  logic [3:0]  we_q, we_d;
  logic [7:0]  cur_byte, crc_upd;
  logic [31:0] slots_new;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  assign s_ready_o = (state_q == IDLE);
  assign busy_o    = (state_q != IDLE);
  assign data_o    = dout_q;
  assign we_o      = we_q;

  // next-state: accept a word, walk its four byte lanes, then deposit the CRC or flush
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    be_d       = be_q;
    last_d     = last_q;
    crc_d      = crc_q;
    slot_cnt_d = slot_cnt_q;
    slots_d    = slots_q;
    dout_d     = dout_q;
    we_d       = 4'h0;
    cur_byte   = word_q[{idx_q, 3'b000} +: 8];
    crc_upd    = be_q[idx_q] ? crc8_byte(crc_q, cur_byte) : crc_q;
    slots_new  = slots_q;
    slots_new[{slot_cnt_q, 3'b000} +: 8] = crc_upd;
    if (state_q == IDLE) begin
      if (s_valid_i) begin
        word_d  = s_data_i;
        be_d    = s_be_i;
        last_d  = s_last_i;
        idx_d   = 2'd0;
        state_d = PROC;
      end else if (flush_i && slot_cnt_q != 2'd0) begin
        we_d       = (4'd1 << slot_cnt_q) - 4'd1;
        dout_d     = slots_q;
        slot_cnt_d = 2'd0;
        slots_d    = 32'h0;
      end
    end else begin
      crc_d = crc_upd;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        state_d = IDLE;
        if (last_q) begin
          crc_d = INIT;
          if (slot_cnt_q == 2'd3) begin
            we_d       = 4'hF;
            dout_d     = slots_new;
            slots_d    = 32'h0;
            slot_cnt_d = 2'd0;
          end else begin
            slots_d    = slots_new;
            slot_cnt_d = slot_cnt_q + 2'd1;
          end
        end
      end
    end
  end

  // state registers; reset drops any partial CRC and slot contents
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      word_q     <= 32'h0;
      be_q       <= 4'h0;
      last_q     <= 1'b0;
      crc_q      <= INIT;
      slot_cnt_q <= 2'd0;
      slots_q    <= 32'h0;
      dout_q     <= 32'h0;
      we_q       <= 4'h0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      be_q       <= be_d;
      last_q     <= last_d;
      crc_q      <= crc_d;
      slot_cnt_q <= slot_cnt_d;
      slots_q    <= slots_d;
      dout_q     <= dout_d;
      we_q       <= we_d;
    end
  end
endmodule

// File: tb/tb_crc8_packet_engine.sv
// tb_crc8_packet_engine: directed table, corner sequences and random traffic against a byte-queue CRC model
module tb_crc8_packet_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] s_data_i = 32'h0;
  logic [3:0]  s_be_i = 4'h0;
  logic        s_last_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] data_o;
  logic [3:0]  we_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        is_flush;
    logic [31:0] d;
    logic [3:0]  be;
    logic        last;
    logic [3:0]  we;
    logic [31:0] dout;
  } vec_t;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] d;
  } wr_t;

  logic [7:0] pkt[$];
  logic [7:0] sl[$];
  wr_t        exp_q[$];
  vec_t       tbl[11];

  crc8_packet_engine dut (
    .clk(clk), .reset(reset), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_data_i(s_data_i), .s_be_i(s_be_i), .s_last_i(s_last_i), .flush_i(flush_i),
    .data_o(data_o), .we_o(we_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] ref_crc();
    logic [7:0] c = 8'h00;
    logic fb;
    foreach (pkt[i])
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ pkt[i][b];
        c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    return c;
  endfunction

  function automatic logic [31:0] pack_slots();
    logic [31:0] w = 32'h0;
    foreach (sl[i]) w[8*i +: 8] = sl[i];
    return w;
  endfunction

  task automatic model_word(input logic [31:0] d, input logic [3:0] be, input logic last);
    for (int k = 0; k < 4; k++) if (be[k]) pkt.push_back(d[8*k +: 8]);
    if (last) begin
      sl.push_back(ref_crc());
      pkt.delete();
      if (sl.size() == 4) begin
        exp_q.push_back('{4'hF, pack_slots()});
        sl.delete();
      end
    end
  endtask

  task automatic model_flush();
    if (sl.size() > 0) begin
      exp_q.push_back('{4'((1 << sl.size()) - 1), pack_slots()});
      sl.delete();
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready_o) chk("ready_timeout", 32'(s_ready_o), 32'h1);
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] be, input logic last, input logic fl);
    wait_ready();
    s_data_i = d; s_be_i = be; s_last_i = last; s_valid_i = 1'b1; flush_i = fl;
    @(posedge clk); #1;
    s_valid_i = 1'b0; flush_i = 1'b0;
    model_word(d, be, last);
  endtask

  task automatic do_flush();
    wait_ready();
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    model_flush();
  endtask

  // every write the engine makes must be the next one the model predicts
  always @(negedge clk) begin
    if (!reset && we_o != 4'h0) begin
      if (exp_q.size() == 0) chk("unexpected_write", {we_o, data_o[27:0]}, 32'h0);
      else begin
        chk("wr_we", 32'(we_o), 32'(exp_q[0].we));
        chk("wr_data", data_o, exp_q[0].d);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    tbl[0]  = '{1'b0, 32'h34333231, 4'hF, 1'b0, 4'h0, 32'h0};
    tbl[1]  = '{1'b0, 32'h38373635, 4'hF, 1'b0, 4'h0, 32'h0};
    tbl[2]  = '{1'b0, 32'h00000039, 4'h1, 1'b1, 4'h0, 32'h0};
    tbl[3]  = '{1'b1, 32'h0, 4'h0, 1'b0, 4'h1, 32'h000000F4};
    tbl[4]  = '{1'b1, 32'h0, 4'h0, 1'b0, 4'h0, 32'h000000F4};
    tbl[5]  = '{1'b0, 32'h00000000, 4'h1, 1'b1, 4'h0, 32'h000000F4};
    tbl[6]  = '{1'b0, 32'h00000001, 4'h1, 1'b1, 4'h0, 32'h000000F4};
    tbl[7]  = '{1'b0, 32'h000000FF, 4'h1, 1'b1, 4'h0, 32'h000000F4};
    tbl[8]  = '{1'b0, 32'h00000000, 4'h1, 1'b1, 4'hF, 32'h00F30700};
    tbl[9]  = '{1'b0, 32'hFF00AA01, 4'h1, 1'b1, 4'h0, 32'h00F30700};
    tbl[10] = '{1'b1, 32'h0, 4'h0, 1'b0, 4'h1, 32'h00000007};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("idle_state", {s_ready_o, busy_o, we_o, data_o[25:0]}, {1'b1, 1'b0, 4'h0, 26'h0});
      @(posedge clk); #1;
    end

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].is_flush) do_flush();
      else begin
        send(tbl[i].d, tbl[i].be, tbl[i].last, 1'b0);
        chk("proc_busy", {31'h0, busy_o & ~s_ready_o}, 32'h1);
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); #1;
          chk("no_early_write", 32'(we_o), 32'h0);
        end
        @(posedge clk); #1;
        chk("ready_again", 32'(s_ready_o), 32'h1);
      end
      chk($sformatf("tbl%0d_we", i), 32'(we_o), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_data", i), data_o, tbl[i].dout);
    end

    send(32'h00000012, 4'h1, 1'b1, 1'b0);
    flush_i = 1'b1;
    repeat (4) @(posedge clk);
    #1 flush_i = 1'b0;
    chk("flush_in_proc_t5", 32'(we_o), 32'h0);
    @(posedge clk); #1;
    chk("flush_in_proc_t6", 32'(we_o), 32'h0);

    send(32'hDEADBEEF, 4'h0, 1'b0, 1'b1);
    chk("flush_with_accept", 32'(we_o), 32'h0);
    repeat (4) @(posedge clk);
    #1 chk("flush_with_accept_t5", 32'(we_o), 32'h0);
    do_flush();
    chk("flush_after_drop_we", 32'(we_o), 32'h1);
    chk("flush_after_drop_data", data_o, 32'h0000007E);

    send(32'h000000AB, 4'h1, 1'b1, 1'b0);
    send(32'h34333231, 4'hF, 1'b0, 1'b0);
    send(32'h38373635, 4'hF, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pkt.delete(); sl.delete(); exp_q.delete();
    chk("post_reset", {s_ready_o, busy_o, we_o, data_o[25:0]}, {1'b1, 1'b0, 4'h0, 26'h0});
    send(32'h34333231, 4'hF, 1'b0, 1'b0);
    send(32'h38373635, 4'hF, 1'b0, 1'b0);
    send(32'h00000039, 4'h1, 1'b1, 1'b0);
    do_flush();
    chk("reset_resend_we", 32'(we_o), 32'h1);
    chk("reset_resend_data", data_o, 32'h000000F4);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) do_flush();
      else send($urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), 1'b0);
    end
    do_flush();
    repeat (6) @(posedge clk);
    #1 chk("all_writes_seen", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
